// File: rtl/alarm_text_ctrl.sv
// Alarm overlay sequencer: idle/ringing/snooze FSM, blink, buzzer and text strip position.
// Define ALARM_TEXT_BOUNCE_EN to make the strip bounce around the screen while ringing.
module alarm_text_ctrl #(
  parameter int BLINK_FRAMES        = 30,
  parameter int RING_TIMEOUT_FRAMES = 3600,
  parameter int SNOOZE_FRAMES       = 18000,
  parameter int HOME_X              = 256,
  parameter int HOME_Y              = 232
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       alarm_armed,
  input  logic       alarm_match,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic [9:0] top_left_x,
  output logic [9:0] top_left_y,
  output logic       text_en,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam int BW = (BLINK_FRAMES > 1)        ? $clog2(BLINK_FRAMES)        : 1;
  localparam int RW = (RING_TIMEOUT_FRAMES > 1) ? $clog2(RING_TIMEOUT_FRAMES) : 1;
  localparam int SW = (SNOOZE_FRAMES > 1)       ? $clog2(SNOOZE_FRAMES)       : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [RW-1:0] RING_LAST  = RW'(RING_TIMEOUT_FRAMES - 1);
  localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_FRAMES - 1);
  localparam logic [9:0]    HOME_X_C   = 10'(HOME_X);
  localparam logic [9:0]    HOME_Y_C   = 10'(HOME_Y);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic          match_prev_q;
  logic          phase_q, phase_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          text_en_q, text_en_d;
  logic          buzzer_q, buzzer_d;
  logic          to_idle;
  logic          match_rise;
`ifdef ALARM_TEXT_BOUNCE_EN
  localparam logic [9:0] MAX_X = 10'd512;
  localparam logic [9:0] MAX_Y = 10'd464;
  logic dx_q, dx_d, dy_q, dy_d;
`endif

  assign match_rise = alarm_match & ~match_prev_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    ring_cnt_d  = ring_cnt_q;
    snz_cnt_d   = snz_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    to_idle     = 1'b0;
`ifdef ALARM_TEXT_BOUNCE_EN
    dx_d        = dx_q;
    dy_d        = dy_q;
`endif
    case (state_q)
      IDLE: begin
        if (match_rise && alarm_armed) begin
          state_d     = RINGING;
          phase_d     = 1'b1;
          blink_cnt_d = '0;
          ring_cnt_d  = '0;
        end
      end
      RINGING: begin
        if (stop_btn || !alarm_armed) begin
          to_idle = 1'b1;
        end else if (snooze_btn) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
        end else if (frame_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            to_idle = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 1'b1;
            end
`ifdef ALARM_TEXT_BOUNCE_EN
            // At a bound facing outward: reverse and step inward on the same tick.
            if (dx_q) begin
              if (x_q >= MAX_X) begin dx_d = 1'b0; x_d = x_q - 10'd1; end
              else              x_d = x_q + 10'd1;
            end else begin
              if (x_q == 10'd0) begin dx_d = 1'b1; x_d = x_q + 10'd1; end
              else              x_d = x_q - 10'd1;
            end
            if (dy_q) begin
              if (y_q >= MAX_Y) begin dy_d = 1'b0; y_d = y_q - 10'd1; end
              else              y_d = y_q + 10'd1;
            end else begin
              if (y_q == 10'd0) begin dy_d = 1'b1; y_d = y_q + 10'd1; end
              else              y_d = y_q - 10'd1;
            end
`endif
          end
        end
      end
      SNOOZE: begin
        if (stop_btn || !alarm_armed) begin
          to_idle = 1'b1;
        end else if (frame_tick) begin
          // Strip returns home on a frame boundary so it never tears mid-frame.
          x_d = HOME_X_C;
          y_d = HOME_Y_C;
          if (snz_cnt_q == SNZ_LAST) begin
            state_d     = RINGING;
            ring_cnt_d  = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d     = IDLE;
      blink_cnt_d = '0;
      ring_cnt_d  = '0;
      snz_cnt_d   = '0;
      x_d         = HOME_X_C;
      y_d         = HOME_Y_C;
`ifdef ALARM_TEXT_BOUNCE_EN
      dx_d        = 1'b1;
      dy_d        = 1'b1;
`endif
    end
    text_en_d = ((state_d == RINGING) && phase_d) || (state_d == SNOOZE);
    buzzer_d  = (state_d == RINGING);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      match_prev_q <= 1'b0;
      phase_q      <= 1'b1;
      blink_cnt_q  <= '0;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      x_q          <= HOME_X_C;
      y_q          <= HOME_Y_C;
      text_en_q    <= 1'b0;
      buzzer_q     <= 1'b0;
`ifdef ALARM_TEXT_BOUNCE_EN
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      match_prev_q <= alarm_match;
      phase_q      <= phase_d;
      blink_cnt_q  <= blink_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      text_en_q    <= text_en_d;
      buzzer_q     <= buzzer_d;
`ifdef ALARM_TEXT_BOUNCE_EN
      dx_q         <= dx_d;
      dy_q         <= dy_d;
`endif
    end
  end

  assign state      = state_q;
  assign top_left_x = x_q;
  assign top_left_y = y_q;
  assign text_en    = text_en_q;
  assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_alarm_text_ctrl.sv
// Directed bench for alarm_text_ctrl with short blink/timeout/snooze periods.
module tb_alarm_text_ctrl;

`ifdef ALARM_TEXT_BOUNCE_EN
  localparam int HX = 511;
  localparam int HY = 463;
`else
  localparam int HX = 256;
  localparam int HY = 232;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_tick, alarm_armed, alarm_match, snooze_btn, stop_btn;
  logic [9:0] top_left_x, top_left_y;
  logic       text_en, buzzer;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;

  alarm_text_ctrl #(
    .BLINK_FRAMES(2), .RING_TIMEOUT_FRAMES(8), .SNOOZE_FRAMES(5),
    .HOME_X(HX), .HOME_Y(HY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .alarm_armed(alarm_armed), .alarm_match(alarm_match),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .top_left_x(top_left_x), .top_left_y(top_left_y),
    .text_en(text_en), .buzzer(buzzer), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic trigger();
    alarm_match = 1'b0;
    @(negedge clk);
    alarm_match = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; alarm_armed = 1'b0;
    alarm_match = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_text_en", text_en, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_x", top_left_x, HX);
    chk("rst_y", top_left_y, HY);
    reset_n = 1'b1;
    cyc(2);

    // Arm and trigger, blink, timeout
    alarm_armed = 1'b1;
    cyc(1);
    alarm_match = 1'b1;
    cyc(1);
    chk("trig_state", state, 1);
    chk("trig_buzzer", buzzer, 1);
    chk("trig_text_en", text_en, 1);
    tick();
    chk("blink_t1", text_en, 1);
    tick();
    chk("blink_t2", text_en, 0);
    repeat (5) tick();
    chk("ring_t7_state", state, 1);
    tick();
    chk("timeout_state", state, 0);
    chk("timeout_buzzer", buzzer, 0);
    chk("timeout_text_en", text_en, 0);
    cyc(10);
    chk("no_retrigger", state, 0);

    // Snooze cycle
    trigger();
    chk("ring2_state", state, 1);
    snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
    chk("snz_state", state, 2);
    chk("snz_text_en", text_en, 1);
    chk("snz_buzzer", buzzer, 0);
    snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
    chk("snz_btn_ignored", state, 2);
    repeat (4) tick();
    chk("snz_t4_state", state, 2);
    tick();
    chk("rering_state", state, 1);
    chk("rering_text_en", text_en, 1);
    chk("rering_buzzer", buzzer, 1);

    // Priority: stop beats snooze
    stop_btn = 1'b1; snooze_btn = 1'b1; cyc(1);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("stop_prio_state", state, 0);

    // Timeout tick coinciding with snooze takes snooze
    trigger();
    repeat (7) tick();
    chk("pre_timeout_state", state, 1);
    frame_tick = 1'b1; snooze_btn = 1'b1; cyc(1);
    frame_tick = 1'b0; snooze_btn = 1'b0;
    chk("timeout_vs_snz", state, 2);

    // Disarm in snooze
    alarm_armed = 1'b0; cyc(1);
    chk("disarm_state", state, 0);
    chk("disarm_x", top_left_x, HX);
    alarm_armed = 1'b1;

    // Async reset while ringing
    trigger();
    tick();
    chk("pre_rst_buzzer", buzzer, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_buzzer", buzzer, 0);
    chk("async_rst_text_en", text_en, 0);
    chk("async_rst_x", top_left_x, HX);
    chk("async_rst_y", top_left_y, HY);
    alarm_match = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    chk("post_rst_state", state, 0);

`ifdef ALARM_TEXT_BOUNCE_EN
    // Bounce from near the corner
    trigger();
    chk("bnc_home_x", top_left_x, 511);
    chk("bnc_home_y", top_left_y, 463);
    cyc(3);
    chk("bnc_hold_x", top_left_x, 511);
    tick();
    chk("bnc_t1_x", top_left_x, 512);
    chk("bnc_t1_y", top_left_y, 464);
    cyc(3);
    chk("bnc_hold2_x", top_left_x, 512);
    chk("bnc_hold2_y", top_left_y, 464);
    tick();
    chk("bnc_t2_x", top_left_x, 511);
    chk("bnc_t2_y", top_left_y, 463);
    tick();
    chk("bnc_t3_x", top_left_x, 510);
    chk("bnc_t3_y", top_left_y, 462);
    stop_btn = 1'b1; cyc(1); stop_btn = 1'b0;
    chk("bnc_stop_x", top_left_x, 511);
    chk("bnc_stop_y", top_left_y, 463);
`else
    // Fixed position across 20 ringing ticks
    trigger();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("fixed_x", top_left_x, 256);
      chk("fixed_y", top_left_y, 232);
      if (state == 2'b00) trigger();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_text_ctrl.md
# alarm_text_ctrl

Sequences the on-screen "ALARM" text overlay and buzzer for the VGA alarm clock. It owns the alarm state machine (idle, ringing, snoozed) and decides whether the 128×16 text glyph strip is shown. It also sets the blink rate and the strip's top-left position. It sits between the time/alarm comparator and the text renderer, driving the renderer's `top_left_x`/`top_left_y` and gating its `on` output with `text_en`.

## Interface
- `BLINK_FRAMES`, 30: frame ticks per blink half-period while ringing.
- `RING_TIMEOUT_FRAMES`, 3600: frame ticks of unattended ringing before auto-stop.
- `SNOOZE_FRAMES`, 18000: frame ticks spent in snooze before re-ringing.
- `HOME_X`, 256: idle/home top-left x.
- `HOME_Y`, 232: idle/home top-left y.

Ports:
- `clk`  in  1  pixel/system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse once per frame, at start of vertical blank.
- `alarm_armed`  in  1  level; alarm enabled by user.
- `alarm_match`  in  1  level; current time equals alarm time (may stay high for a full minute).
- `snooze_btn`  in  1  debounced single-cycle pulse.
- `stop_btn`  in  1  debounced single-cycle pulse.
- `top_left_x`  out  10  text strip x origin.
- `top_left_y`  out  10  text strip y origin.
- `text_en`  out  1  renderer gate.
- `buzzer`  out  1  buzzer drive.
- `state`  out  2  IDLE=00, RINGING=01, SNOOZE=10.

## Operation
- FSM states are IDLE, RINGING and SNOOZE. All outputs are registered.
- Rising edge of `alarm_match` is detected with a registered previous value, which resets to 0.
- IDLE → RINGING on a rising edge of `alarm_match` with `alarm_armed`=1. A held-high `alarm_match` never retriggers.
- RINGING exits, in priority order:
  - `stop_btn` → IDLE.
  - `alarm_armed`=0 → IDLE.
  - `snooze_btn` → SNOOZE.
  - `frame_tick` that completes RING_TIMEOUT_FRAMES ticks since entry → IDLE.
- SNOOZE exits, in priority order:
  - `stop_btn` or `alarm_armed`=0 → IDLE.
  - The SNOOZE_FRAMES-th `frame_tick` since entry → RINGING, with the ring counter cleared.
  - `snooze_btn` and `alarm_match` edges are ignored in SNOOZE.
- Counters are cleared on every state entry and advance only on `frame_tick`. Each is sized with $clog2 of its parameter.
- Blink: the `phase` bit is set to 1 on RINGING entry. It toggles on every BLINK_FRAMES-th frame_tick in RINGING.
- Output decode:
  - `text_en` = RINGING & phase, or 1 in SNOOZE, or 0 in IDLE.
  - `buzzer` = 1 only in RINGING.
- Position: held at HOME_X/HOME_Y in IDLE and SNOOZE, and reloaded to home on entry to IDLE. In RINGING it changes only on `frame_tick`; see Configuration.

## Timing
- Reset values: state=IDLE, `top_left_x`=HOME_X, `top_left_y`=HOME_Y, `text_en`=0, `buzzer`=0, phase=1, dx=dy=+1, all counters=0.
- Latency: any input event is reflected on `state`, `text_en` and `buzzer` one clock after the sampling edge.
- `top_left_*` change only in the cycle after a `frame_tick`, or on entry to IDLE. This guarantees no mid-frame tearing.
- `reset_n` low mid-operation forces IDLE immediately, without waiting for a clock edge. Outputs are silent while reset is held.
- A state-exit event coinciding with `frame_tick` takes the exit. The exited state's counters do not advance.

## Configuration
- `ALARM_TEXT_BOUNCE_EN` defined: in RINGING, each `frame_tick` moves the strip by (dx, dy), one pixel per axis.
  - Bounds are x∈[0,512] and y∈[0,464], which keeps the 128×16 strip inside 640×480.
  - If the current coordinate sits at a bound and its direction points outward, the direction flips and the coordinate moves one step inward on the same tick.
  - dx and dy persist across SNOOZE and reset to +1 on entry to IDLE.
- `ALARM_TEXT_BOUNCE_EN` undefined: position is fixed at HOME_X/HOME_Y in all states. The dx/dy registers and the bounds logic are not synthesized.

## Test plan
Benches use BLINK_FRAMES=2, RING_TIMEOUT_FRAMES=8, SNOOZE_FRAMES=5.
- Arm and trigger: armed=1, pulse `alarm_match` high for 100 cycles → state=01 one cycle after the rising edge.
  - `buzzer`=1 and `text_en`=1, toggling to 0 after the 2nd frame_tick.
  - After 8 frame_ticks → state=00, `buzzer`=0.
  - No retrigger while `alarm_match` stays high.
- Snooze cycle: ring, then pulse `snooze_btn` → state=10, `text_en`=1, `buzzer`=0.
  - After 5 frame_ticks → state=01 with `text_en`=1.
- Priority: `stop_btn` and `snooze_btn` in the same cycle while ringing → state=00.
  - Timeout tick plus `snooze_btn` in the same cycle → state=10.
- Disarm and reset: drop `alarm_armed` in SNOOZE → IDLE next cycle.
  - Assert `reset_n`=0 while ringing, between clock edges → `buzzer`=0 and state=00 immediately.
  - Position at (256,232).
- Bounce (macro defined): HOME_X=511, HOME_Y=463, ringing.
  - frame_ticks give (512,464) → (511,463) → (510,462).
  - Position never changes except in the cycle after a frame_tick.
- Bounce (macro undefined): 20 frame_ticks while ringing → position stays (256,232).
